ring_decoder: RTL and testbench

//  Receive-side companion to the team's ring/Johnson counters: samples a ring-coded phase bus and decodes it to a binary index.

---
 rtl/ring_decoder.sv | 157 +++++++++++++++
 tb/tb_ring_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// Ring-coded phase decoder: decodes, tracks lock, counts laps and sequence errors.
// Define RING_DEC_JOHNSON_EN to decode a Johnson (twisted-ring) code instead of one-hot.
module ring_decoder #(
    parameter int WIDTH    = 4,
    parameter int IDX_W    = 2,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] ring_in,
    output logic [IDX_W-1:0] phase,
    output logic             valid,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic [CNT_W-1:0] lap_cnt,
    output logic [CNT_W-1:0] err_cnt
);

`ifdef RING_DEC_JOHNSON_EN
    localparam int NPH = 2 * WIDTH;
`else
    localparam int NPH = WIDTH;
`endif
    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

    state_t             state, state_d;
    logic [RUN_W-1:0]   run_cnt, run_d;
    logic [WIDTH-1:0]   prev_code, code_d, next_code;
    logic [IDX_W-1:0]   phase_d, idx;
    logic               valid_d, locked_d, wrap_d, err_d, legal, advance;
    logic [CNT_W-1:0]   lap_d, errc_d;

    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int b = 0; b < WIDTH; b++) begin
`ifdef RING_DEC_JOHNSON_EN
            c[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
`else
            c[b] = (b == k);
`endif
        end
        return c;
    endfunction

    always_comb begin
        legal = 1'b0;
        idx   = '0;
        for (int k = 0; k < NPH; k++) begin
            if (ring_in == code_of(k)) begin
                legal = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

`ifdef RING_DEC_JOHNSON_EN
    assign next_code = {prev_code[WIDTH-2:0], ~prev_code[WIDTH-1]};
`else
    assign next_code = {prev_code[WIDTH-2:0], prev_code[WIDTH-1]};
`endif

    // prev_code always holds a legal code once outside UNLOCKED, so its successor is legal too
    assign advance = legal && (ring_in == next_code);

    always_comb begin
        state_d  = state;
        run_d    = run_cnt;
        code_d   = prev_code;
        phase_d  = phase;
        valid_d  = valid;
        locked_d = locked;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        lap_d    = lap_cnt;
        errc_d   = err_cnt;
        if (en) begin
            valid_d = legal;
            if (legal) begin
                code_d  = ring_in;
                phase_d = idx;
            end
            case (state)
                UNLOCKED: begin
                    if (legal) begin
                        run_d   = '0;
                        state_d = LOCKING;
                    end
                end
                LOCKING: begin
                    if (advance) begin
                        if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
                            run_d    = '0;
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            run_d = run_cnt + RUN_W'(1);
                        end
                    end else if (legal) begin
                        run_d = '0;
                    end else begin
                        run_d   = '0;
                        state_d = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (advance) begin
                        // the last phase stepping to phase 0 closes a lap
                        if (phase == IDX_W'(NPH - 1)) begin
                            wrap_d = 1'b1;
                            lap_d  = lap_cnt + CNT_W'(1);
                        end
                    end else begin
                        err_d    = 1'b1;
                        errc_d   = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
                        locked_d = 1'b0;
                        run_d    = '0;
                        state_d  = legal ? LOCKING : UNLOCKED;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= UNLOCKED;
            run_cnt   <= '0;
            prev_code <= '0;
            phase     <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            lap_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            run_cnt   <= run_d;
            prev_code <= code_d;
            phase     <= phase_d;
            valid     <= valid_d;
            locked    <= locked_d;
            wrap      <= wrap_d;
            err       <= err_d;
            lap_cnt   <= lap_d;
            err_cnt   <= errc_d;
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// Directed scoreboard bench for ring_decoder (WIDTH=4, LOCK_CNT=2, CNT_W=8).
// Expected outputs packed as {phase, valid, locked, wrap, err, lap_cnt, err_cnt}.
module tb_ring_decoder;

    localparam int WIDTH    = 4;
`ifdef RING_DEC_JOHNSON_EN
    localparam int IDX_W    = 3;
`else
    localparam int IDX_W    = 2;
`endif
    localparam int LOCK_CNT = 2;
    localparam int CNT_W    = 8;
    localparam int EXP_W    = IDX_W + 4 + 2 * CNT_W;

    logic             clk;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic [IDX_W-1:0] phase;
    logic             valid, locked, wrap, err;
    logic [CNT_W-1:0] lap_cnt, err_cnt;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    ring_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .ring_in(ring_in),
        .phase(phase), .valid(valid), .locked(locked), .wrap(wrap), .err(err),
        .lap_cnt(lap_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EXP_W-1:0] got_vec();
        return {phase, valid, locked, wrap, err, lap_cnt, err_cnt};
    endfunction

    task automatic check(input string nm, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got {phase,valid,locked,wrap,err,lap,errc}=%h required %h", nm, got, expv);
    endtask

    // Issue one sample and queue the outputs it must produce after the next edge.
    task automatic step(input logic e, input logic [WIDTH-1:0] r, input int ph, input logic v,
                        input logic l, input logic w, input logic er, input int lap, input int ec,
                        input string nm);
        @(negedge clk);
        en      = e;
        ring_in = r;
        exp_q.push_back({IDX_W'(ph), v, l, w, er, CNT_W'(lap), CNT_W'(ec)});
        name_q.push_back(nm);
    endtask

    // Monitor: every edge, compare against the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check(name_q.pop_front(), got_vec(), exp_q.pop_front());
        end
    end

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d expectations outstanding, required 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b1;
        ring_in = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ring_in = (i % 2 == 0) ? 4'b0010 : 4'b0001;
            #1 check("reset_hold", got_vec(), '0);
        end
        @(negedge clk);
        reset   = 1'b1;
        ring_in = 4'b0101;
        #1 check("reset_release", got_vec(), '0);

`ifdef RING_DEC_JOHNSON_EN
        step(1, 4'b0101, 0, 0, 0, 0, 0, 0, 0, "j_illegal_unlocked");
        step(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, "j_ph0");
        step(1, 4'b0001, 1, 1, 0, 0, 0, 0, 0, "j_ph1");
        step(1, 4'b0011, 2, 1, 1, 0, 0, 0, 0, "j_ph2_lock");
        step(1, 4'b0111, 3, 1, 1, 0, 0, 0, 0, "j_ph3");
        step(1, 4'b1111, 4, 1, 1, 0, 0, 0, 0, "j_ph4");
        step(1, 4'b1110, 5, 1, 1, 0, 0, 0, 0, "j_ph5");
        step(1, 4'b1100, 6, 1, 1, 0, 0, 0, 0, "j_ph6");
        step(1, 4'b1000, 7, 1, 1, 0, 0, 0, 0, "j_ph7");
        step(1, 4'b0000, 0, 1, 1, 1, 0, 1, 0, "j_wrap");
        step(1, 4'b0101, 0, 0, 0, 0, 1, 1, 1, "j_err_illegal");
        step(1, 4'b0011, 2, 1, 0, 0, 0, 1, 1, "j_reload");
`else
        step(1, 4'b0011, 0, 0, 0, 0, 0, 0, 0, "illegal_unlocked");
        step(1, 4'b0001, 0, 1, 0, 0, 0, 0, 0, "first_legal");
        step(1, 4'b0010, 1, 1, 0, 0, 0, 0, 0, "advance1");
        step(1, 4'b0100, 2, 1, 1, 0, 0, 0, 0, "lock");
        step(1, 4'b1000, 3, 1, 1, 0, 0, 0, 0, "locked_ph3");
        step(1, 4'b0001, 0, 1, 1, 1, 0, 1, 0, "first_wrap");
        step(0, 4'(($urandom_range(0, 15))), 0, 1, 1, 0, 0, 1, 0, "en0_drops_wrap");
        step(1, 4'b0010, 1, 1, 1, 0, 0, 1, 0, "after_hold");
        for (int i = 2; i <= 256; i++) begin
            step(1, 4'b0100, 2, 1, 1, 0, 0, (i - 1) % 256, 0, "lap_ph2");
            step(1, 4'b1000, 3, 1, 1, 0, 0, (i - 1) % 256, 0, "lap_ph3");
            step(1, 4'b0001, 0, 1, 1, 1, 0, i % 256, 0, "lap_wrap");
            step(1, 4'b0010, 1, 1, 1, 0, 0, i % 256, 0, "lap_ph1");
        end
        step(1, 4'b0100, 2, 1, 1, 0, 0, 0, 0, "locked_ph2");
        step(1, 4'b0110, 2, 0, 0, 0, 1, 0, 1, "err_illegal");
        step(1, 4'b0001, 0, 1, 0, 0, 0, 0, 1, "relock0");
        step(1, 4'b0010, 1, 1, 0, 0, 0, 0, 1, "relock1");
        step(1, 4'b0100, 2, 1, 1, 0, 0, 0, 1, "relocked");
        step(1, 4'b1000, 3, 1, 1, 0, 0, 0, 1, "relocked_ph3");
        step(1, 4'b0001, 0, 1, 1, 1, 0, 1, 1, "relocked_wrap");
        step(1, 4'b0010, 1, 1, 1, 0, 0, 1, 1, "locked_ph1");
        step(1, 4'b0010, 1, 1, 0, 0, 1, 1, 2, "err_stuck");
        for (int i = 0; i < 5; i++)
            step(0, 4'(($urandom_range(0, 15))), 1, 1, 0, 0, 0, 1, 2, "en0_hold");
        step(1, 4'b1000, 3, 1, 0, 0, 0, 1, 2, "locking_reload_no_err");
        step(1, 4'b0001, 0, 1, 0, 0, 0, 1, 2, "locking_no_lap");
        step(1, 4'b0010, 1, 1, 1, 0, 0, 1, 2, "lock_again");
        step(1, 4'b0100, 2, 1, 1, 0, 0, 1, 2, "locked_ph2b");
`endif
        drain();

        // Asynchronous reset between edges clears outputs before the next edge.
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset", got_vec(), '0);
        @(negedge clk);
        reset = 1'b1;
`ifdef RING_DEC_JOHNSON_EN
        step(1, 4'b0011, 2, 1, 0, 0, 0, 0, 0, "post_reset_sample");
`else
        step(1, 4'b0100, 2, 1, 0, 0, 0, 0, 0, "post_reset_sample");
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
